vc_arbiter: RTL

Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1). It picks one VC head word per cycle by round-robin, routes it by its destination bit, and pushes it into D0 or D1. Words are never sent to a destination whose almost-full flag is set. The block is enabled by the `active_out` / `error_out` outputs of `fsmControl` and sits beside it in the module top.

---
 rtl/vc_arbiter_pkg.sv | 15 +
 rtl/rr_arb2.sv | 27 ++
 rtl/vc_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/vc_arbiter_pkg.sv
// Shared encodings for the VC scheduler: FSM states, FIFO indices and width defaults.
package vc_arbiter_pkg;
  typedef enum logic [2:0] {
    ARB_IDLE = 3'b001,
    ARB_RUN  = 3'b010,
    ARB_HALT = 3'b100
  } arb_state_e;

  localparam int VC0_IDX      = 0;
  localparam int VC1_IDX      = 1;
  localparam int NUM_VC       = 2;
  localparam int DATA_W_DEF   = 6;
  localparam int DEST_BIT_DEF = 4;
  localparam int CNT_W_DEF    = 8;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // last_q = 1 means requester 1 was granted last, so requester 0 wins the first tie.
  assign last_d = (|req_i) ? gnt_o[1] : last_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) last_q <= 1'b1;
    else          last_q <= last_d;
  end
endmodule

// File: rtl/vc_arbiter.sv
// Schedules VC0/VC1 head words into destination FIFOs D0/D1, one word per cycle,
// with per-VC head-of-line blocking on destination almost-full.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEST_BIT = DEST_BIT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              active_in,
  input  logic              error_in,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [DATA_W-1:0] d_data,
  output logic [CNT_W-1:0]  d0_count,
  output logic [CNT_W-1:0]  d1_count,
  output logic              halted
);
  arb_state_e state_q, state_d;

  logic [NUM_VC-1:0][DATA_W-1:0] head;
  logic [NUM_VC-1:0]             nonempty, req, gnt;
  logic [1:0]                    af;
  logic                          arb_en;
  logic [DATA_W-1:0]             sel, data_q, data_d;
  logic [1:0]                    push_q, push_d;
  logic [CNT_W-1:0]              cnt0_q, cnt1_q;

  assign head[VC0_IDX]     = vc0_data;
  assign head[VC1_IDX]     = vc1_data;
  assign nonempty[VC0_IDX] = ~vc0_empty;
  assign nonempty[VC1_IDX] = ~vc1_empty;
  assign af                = {d1_almost_full, d0_almost_full};

  // error_in suppresses grants in the same cycle so nothing is popped on the way into HALT.
  assign arb_en = (state_q == ARB_RUN) && active_in && !error_in;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_req
    assign req[v] = arb_en && nonempty[v] && !af[head[v][DEST_BIT]];
  end

  rr_arb2 u_rr (
    .clk     (clk),
    .reset_L (reset_L),
    .req_i   (req),
    .gnt_o   (gnt)
  );

  assign vc0_pop = gnt[VC0_IDX];
  assign vc1_pop = gnt[VC1_IDX];

  assign sel    = gnt[VC1_IDX] ? head[VC1_IDX] : head[VC0_IDX];
  assign push_d = (|gnt) ? (sel[DEST_BIT] ? 2'b10 : 2'b01) : 2'b00;
  assign data_d = (|gnt) ? sel : data_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (active_in)  state_d = ARB_RUN;
      ARB_RUN:  if (!active_in) state_d = ARB_IDLE;
      ARB_HALT: state_d = ARB_HALT;
      default:  state_d = ARB_IDLE;
    endcase
    if (error_in) state_d = ARB_HALT;
  end

  // Push registers load regardless of the FSM so an in-flight word always lands.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ARB_IDLE;
      push_q  <= 2'b00;
      data_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
      data_q  <= data_d;
      if (push_q[0]) cnt0_q <= cnt0_q + 1'b1;
      if (push_q[1]) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign d0_push  = push_q[0];
  assign d1_push  = push_q[1];
  assign d_data   = data_q;
  assign d0_count = cnt0_q;
  assign d1_count = cnt1_q;
  assign halted   = (state_q == ARB_HALT);
endmodule
